// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard sequencer.
`default_nettype none

package hazard_pkg;

  localparam int MEM_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  // Memory-stage result is younger than writeback, so it wins on a double match.
  function automatic fwd_sel_t fwd_select(
    input logic [3:0] src,
    input logic [3:0] wa_m,
    input logic       rw_m,
    input logic [3:0] wa_w,
    input logic       rw_w
  );
    if (rw_m && (wa_m == src)) return FWD_M;
    else if (rw_w && (wa_w == src)) return FWD_W;
    else return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// mem_wait_fsm: freezes the pipeline while a multi-cycle data access in M is pending,
// abandoning the access after MEM_TIMEOUT wait cycles and latching a sticky error.
`default_nettype none

module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MemReqM,
  input  logic MemReadyM,
  output logic memStall_o,
  output logic mem_err_o
);

  localparam int             CW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  TIMEOUT_C = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0]  ONE_C     = CW'(1);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    memStall_o = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          memStall_o = 1'b1;
          state_d    = M_WAIT;
          cnt_d      = ONE_C;
        end
      end
      M_WAIT: begin
        // A dropped request means the access was flushed away; nothing to wait for.
        if (!MemReqM || MemReadyM) begin
          state_d = M_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < TIMEOUT_C) begin
          memStall_o = 1'b1;
          cnt_d      = cnt_q + ONE_C;
        end else begin
          err_d   = 1'b1;
          state_d = M_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = M_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= M_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stall/flush enables and stall-cycle counter for the
// 5-stage pipeline; state advances on the falling clock edge with the pipeline registers.
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             ldr_stall;
  logic             pc_wr_pend;
  logic             mem_stall;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .memStall_o (mem_stall),
    .mem_err_o  (mem_err)
  );

  assign ldr_stall  = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst_n) begin
      ForwardAE = fwd_select(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
      ForwardBE = fwd_select(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      // E is frozen, so branch and load-use actions simply re-evaluate on release.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall | pc_wr_pend;
      StallD = ldr_stall;
      FlushD = pc_wr_pend | PCSrcW | BranchTakenE;
      FlushE = ldr_stall | BranchTakenE;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (StallF && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [3:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .MemReqM      (MemReqM),
    .MemReadyM    (MemReadyM),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  task automatic idle_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd15; WA3M = 4'd15; WA3W = 4'd15;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; PCSrcD = 1'b1;
    MemReqM = 1'b1; BranchTakenE = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b0000111) begin
      errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, 7'b0000111);
    end
    checks++;
    if ({ForwardAE, ForwardBE, mem_err, stall_cycles} !== 9'b0) begin
      errors++; $display("FAIL reset_state: got fa=%b fb=%b err=%b cnt=%0d exp all 0",
                         ForwardAE, ForwardBE, mem_err, stall_cycles);
    end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    checks++;
    if ({ctl, mem_err, stall_cycles} !== 12'b0) begin
      errors++; $display("FAIL post_reset_idle: got ctl=%b err=%b cnt=%0d exp 0", ctl, mem_err, stall_cycles);
    end
  endtask

  task automatic test_forwarding();
    next_cycle();
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_m_prio: got %b exp 10", ForwardAE);
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_w: got %b exp 01", ForwardAE);
    end
    WA3W = 4'd4;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_rf: got %b exp 00", ForwardAE);
    end
    RA2E = 4'd7; WA3W = 4'd7; RegWriteW = 1'b1; WA3M = 4'd7; RegWriteM = 1'b0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      errors++; $display("FAIL fwd_b_w: got A=%b B=%b exp A=00 B=01", ForwardAE, ForwardBE);
    end
    RegWriteM = 1'b1;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin
      errors++; $display("FAIL fwd_b_m: got A=%b B=%b exp A=00 B=10", ForwardAE, ForwardBE);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    @(posedge clk);
    checks++;
    if (ctl !== 7'b1100010) begin
      errors++; $display("FAIL ldr_stall: got %b exp %b", ctl, 7'b1100010);
    end
    next_cycle();
    idle_inputs();
    @(posedge clk);
    checks++;
    if ({StallF, StallD, FlushE, stall_cycles} !== 7'b000_0001) begin
      errors++; $display("FAIL ldr_release: got sf=%b sd=%b fe=%b cnt=%0d exp 0 0 0 1",
                         StallF, StallD, FlushE, stall_cycles);
    end
    next_cycle();
    MemtoRegE = 1'b1; RegWriteE = 1'b0; WA3E = 4'd5; RA1D = 4'd5;
    @(posedge clk);
    checks++;
    if (ctl !== 7'b0000000) begin
      errors++; $display("FAIL ldr_no_regwrite: got %b exp %b", ctl, 7'b0000000);
    end
    idle_inputs();
  endtask

  task automatic test_branch_pcsrc();
    do_reset();
    BranchTakenE = 1'b1;
    @(posedge clk);
    checks++;
    if (ctl !== 7'b0000110) begin
      errors++; $display("FAIL branch: got %b exp %b", ctl, 7'b0000110);
    end
    next_cycle();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
    @(posedge clk);
    checks++;
    if (ctl !== 7'b1100110) begin
      errors++; $display("FAIL ldr_plus_branch: got %b exp %b", ctl, 7'b1100110);
    end
    next_cycle();
    idle_inputs();
    PCSrcW = 1'b1;
    @(posedge clk);
    checks++;
    if (ctl !== 7'b0000100) begin
      errors++; $display("FAIL pcsrc_w: got %b exp %b", ctl, 7'b0000100);
    end
    next_cycle();
    idle_inputs();
    PCSrcE = 1'b1;
    @(posedge clk);
    checks++;
    if (ctl !== 7'b1000100) begin
      errors++; $display("FAIL pcsrc_e: got %b exp %b", ctl, 7'b1000100);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) BranchTakenE = 1'b1;
      @(posedge clk);
      checks++;
      if (ctl !== 7'b1111001) begin
        errors++; $display("FAIL memwait_cyc%0d: got %b exp %b", i, ctl, 7'b1111001);
      end
      next_cycle();
    end
    MemReadyM = 1'b1;
    @(posedge clk);
    checks++;
    if (ctl !== 7'b0000110) begin
      errors++; $display("FAIL memwait_release: got %b exp %b", ctl, 7'b0000110);
    end
    next_cycle();
    idle_inputs();
    @(posedge clk);
    checks++;
    if (stall_cycles !== 4'd3) begin
      errors++; $display("FAIL memwait_count: got %0d exp 3", stall_cycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      checks++;
      if ({StallF, StallM, mem_err} !== 3'b110) begin
        errors++; $display("FAIL timeout_wait%0d: got sf=%b sm=%b err=%b exp 1 1 0", i, StallF, StallM, mem_err);
      end
      next_cycle();
    end
    @(posedge clk);
    checks++;
    if ({StallF, StallM, FlushW, mem_err} !== 4'b0000) begin
      errors++; $display("FAIL timeout_release: got sf=%b sm=%b fw=%b err=%b exp 0 0 0 0",
                         StallF, StallM, FlushW, mem_err);
    end
    next_cycle();
    @(posedge clk);
    checks++;
    if ({mem_err, StallF, stall_cycles} !== 6'b1_1_0100) begin
      errors++; $display("FAIL timeout_err: got err=%b sf=%b cnt=%0d exp 1 1 4", mem_err, StallF, stall_cycles);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    @(posedge clk);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b exp 1", mem_err);
    end
    next_cycle();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ctl, mem_err, stall_cycles} !== 12'b0000111_0_0000) begin
      errors++; $display("FAIL midwait_reset: got ctl=%b err=%b cnt=%0d exp 0000111 0 0", ctl, mem_err, stall_cycles);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      checks++;
      if (StallF !== (i < 4)) begin
        errors++; $display("FAIL reset_rewait%0d: got %b exp %b", i, StallF, (i < 4));
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    PCSrcD = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      if (i == 14) begin
        checks++;
        if (stall_cycles !== 4'd14) begin
          errors++; $display("FAIL sat_count14: got %0d exp 14", stall_cycles);
        end
      end
    end
    @(posedge clk);
    checks++;
    if ({StallF, stall_cycles} !== 5'b1_1111) begin
      errors++; $display("FAIL sat_hold: got sf=%b cnt=%0d exp 1 15", StallF, stall_cycles);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_after: got %0d exp 15", stall_cycles);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_pcsrc();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
